axi_lite_cmd_master: RTL and testbench

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

---
 rtl/axi_cmd_pkg.sv | 16 +
 rtl/axi_lite_cmd_master.sv | 142 ++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_cmd_pkg.sv
// Shared types for the AXI4-Lite command master: FSM state encoding and response codes.
package axi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Converts a simple command/response handshake into single AXI4-Lite transactions,
// one outstanding at a time.
module axi_lite_cmd_master
  import axi_cmd_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_write,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  state_t                            r_state, w_next;
  logic                              r_cmd_ready;
  logic                              r_awvalid, r_wvalid, r_arvalid;
  logic                              r_write;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_data;
  logic [1:0]                        r_rsp_resp;

  logic w_cmd_hs, w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic w_aw_done, w_w_done;

  assign w_cmd_hs  = cmd_valid & r_cmd_ready;
  assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid & M_AXI_WREADY;
  assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
  assign w_b_hs    = (r_state == WR_B) & M_AXI_BVALID;
  assign w_r_hs    = (r_state == RD_R) & M_AXI_RVALID;
  // A channel is finished once its valid has dropped or it is handshaking right now.
  assign w_aw_done = ~r_awvalid | M_AXI_AWREADY;
  assign w_w_done  = ~r_wvalid | M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs) w_next = cmd_write ? WR_AW_W : RD_AR;
      WR_AW_W: if (w_aw_done && w_w_done) w_next = WR_B;
      WR_B:    if (M_AXI_BVALID) w_next = RSP;
      RD_AR:   if (w_ar_hs) w_next = RD_R;
      RD_R:    if (M_AXI_RVALID) w_next = RSP;
      RSP:     if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    M_AXI_BREADY = (r_state == WR_B);
    M_AXI_RREADY = (r_state == RD_R);
    rsp_valid    = (r_state == RSP);
  end

  // cmd_ready is a flop so it reads 0 while reset is held and rises one edge after release.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_cmd_ready <= (w_next == IDLE);
      if (w_cmd_hs) begin
        r_write   <= cmd_write;
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
        r_arvalid <= ~cmd_write;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
        if (w_ar_hs) r_arvalid <= 1'b0;
      end
      if (w_b_hs) begin
        r_rsp_data <= '0;
        r_rsp_resp <= M_AXI_BRESP;
      end else if (w_r_hs) begin
        r_rsp_data <= M_AXI_RDATA;
        r_rsp_resp <= M_AXI_RRESP;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_data      = r_rsp_data;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_write     = r_write;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master; the slave side is driven cycle by cycle from each test.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    tick(); tick();
    checks++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
      failures++; $display("FAIL reset_handshakes got=%b exp=0000000",
        {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({rsp_data, rsp_resp, rsp_write, awaddr, wdata, wstrb, araddr} !== '0) begin
      failures++; $display("FAIL reset_payload got rsp_data=%h awaddr=%h wdata=%h exp all 0",
        rsp_data, awaddr, wdata);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    awready = 1; wready = 1;
    issue(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
    checks++;
    if ({awvalid, wvalid, cmd_ready, awaddr, wdata, wstrb, awprot} !== {3'b110, 16'h0004, 32'hDEADBEEF, 4'hF, 3'b000}) begin
      failures++; $display("FAIL wr_aw_w got v=%b%b rdy=%b a=%h d=%h s=%h p=%b exp v=11 rdy=0 a=0004 d=deadbeef s=f p=000",
        awvalid, wvalid, cmd_ready, awaddr, wdata, wstrb, awprot);
    end
    tick();
    awready = 0; wready = 0;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      failures++; $display("FAIL wr_same_cycle_hs got aw/w/b=%b exp=001", {awvalid, wvalid, bready});
    end
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    checks++;
    if ({bready, rsp_valid, rsp_resp, rsp_write, rsp_data} !== {2'b01, 2'b00, 1'b1, 32'h0}) begin
      failures++; $display("FAIL wr_rsp got bready=%b valid=%b resp=%b write=%b data=%h exp 0 1 00 1 0",
        bready, rsp_valid, rsp_resp, rsp_write, rsp_data);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++; $display("FAIL wr_back_to_idle got valid/cmd_ready=%b exp=01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read_ar_delay();
    int stable_bad = 0;
    issue(1'b0, 16'h0008, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (!(arvalid === 1'b1 && araddr === 16'h0008 && arprot === 3'b000 && rready === 1'b0)) stable_bad++;
      if (i == 3) arready = 1;
      tick();
    end
    arready = 0;
    checks++;
    if (stable_bad != 0) begin failures++; $display("FAIL rd_ar_stable got bad_cycles=%0d exp=0", stable_bad); end
    checks++;
    if ({arvalid, rready} !== 2'b01) begin
      failures++; $display("FAIL rd_ar_hs got arvalid/rready=%b exp=01", {arvalid, rready});
    end
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    tick();
    rvalid = 0;
    checks++;
    if ({rready, rsp_valid, rsp_data, rsp_resp, rsp_write} !== {2'b01, 32'h12345678, 2'b00, 1'b0}) begin
      failures++; $display("FAIL rd_rsp got rready=%b valid=%b data=%h resp=%b write=%b exp 0 1 12345678 00 0",
        rready, rsp_valid, rsp_data, rsp_resp, rsp_write);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_aw_before_w();
    int b_accepts = 0;
    awready = 1;
    issue(1'b1, 16'h0010, 32'hA5A50001, 4'h3);
    tick();
    awready = 0;
    checks++;
    if ({awvalid, wvalid, bready, wdata} !== {3'b010, 32'hA5A50001}) begin
      failures++; $display("FAIL aw_first_split got aw/w/b=%b wdata=%h exp 010 a5a50001",
        {awvalid, wvalid, bready}, wdata);
    end
    tick();
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b010) begin
      failures++; $display("FAIL aw_first_w_held got aw/w/b=%b exp=010", {awvalid, wvalid, bready});
    end
    wready = 1;
    tick();
    wready = 0;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      failures++; $display("FAIL aw_first_w_done got aw/w/b=%b exp=001", {awvalid, wvalid, bready});
    end
    // Slave keeps BVALID up for several cycles; only one handshake may occur.
    bvalid = 1; bresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (bready && bvalid) b_accepts++;
      tick();
    end
    bvalid = 0;
    checks++;
    if (b_accepts != 1) begin failures++; $display("FAIL aw_first_one_b got b_accepts=%0d exp=1", b_accepts); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_rsp_backpressure();
    int bad = 0;
    arready = 1;
    issue(1'b0, 16'h0018, 32'h0, 4'h0);
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = 32'h0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0020; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_data === 32'hCAFEF00D && rsp_resp === 2'b00 && rsp_write === 1'b0 &&
            cmd_ready === 1'b0 && {awvalid, wvalid, arvalid, bready, rready} === 5'b0)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rsp_hold got bad_cycles=%0d exp=0", bad); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if ({rsp_valid, cmd_ready, awvalid} !== 3'b010) begin
      failures++; $display("FAIL b2b_ready got valid/cmd_ready/awvalid=%b exp=010", {rsp_valid, cmd_ready, awvalid});
    end
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    checks++;
    if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 16'h0020, 32'h11223344}) begin
      failures++; $display("FAIL b2b_accept got aw/w=%b addr=%h data=%h exp 11 0020 11223344",
        {awvalid, wvalid}, awaddr, wdata);
    end
    tick();
    awready = 0; wready = 0;
    bvalid = 1;
    tick();
    bvalid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    awready = 1; wready = 1;
    issue(1'b1, 16'h0030, 32'h55AA55AA, 4'hC);
    tick();
    awready = 0; wready = 0;
    checks++;
    if (bready !== 1'b1) begin failures++; $display("FAIL rstmid_in_wr_b got bready=%b exp=1", bready); end
    rst_n = 0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, awaddr, wdata} !== '0) begin
      failures++; $display("FAIL rstmid_clear got rdy/v=%b awaddr=%h wdata=%h exp all 0",
        {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, awaddr, wdata);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if ({cmd_ready, rsp_valid, bready} !== 3'b100) begin
      failures++; $display("FAIL rstmid_release got rdy/v/b=%b exp=100", {cmd_ready, rsp_valid, bready});
    end
    arready = 1;
    issue(1'b0, 16'h000C, 32'h0, 4'h0);
    checks++;
    if ({arvalid, araddr} !== {1'b1, 16'h000C}) begin
      failures++; $display("FAIL rstmid_read_ar got arvalid=%b araddr=%h exp 1 000c", arvalid, araddr);
    end
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h0BADF00D; rresp = 2'b00;
    tick();
    rvalid = 0;
    checks++;
    if ({rsp_valid, rsp_data, rsp_resp, rsp_write} !== {1'b1, 32'h0BADF00D, 2'b00, 1'b0}) begin
      failures++; $display("FAIL rstmid_read_rsp got valid=%b data=%h resp=%b write=%b exp 1 0badf00d 00 0",
        rsp_valid, rsp_data, rsp_resp, rsp_write);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_rresp_slverr();
    arready = 1;
    issue(1'b0, 16'h0014, 32'h0, 4'h0);
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'hFFFF0000; rresp = 2'b10;
    tick();
    rvalid = 0; rresp = 2'b00;
    checks++;
    if ({rsp_valid, rsp_resp, rsp_data} !== {1'b1, 2'b10, 32'hFFFF0000}) begin
      failures++; $display("FAIL slverr_rsp got valid=%b resp=%b data=%h exp 1 10 ffff0000",
        rsp_valid, rsp_resp, rsp_data);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if ({rsp_valid, cmd_ready, arvalid} !== 3'b010) begin
      failures++; $display("FAIL slverr_idle got valid/cmd_ready/arvalid=%b exp=010", {rsp_valid, cmd_ready, arvalid});
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_ar_delay();
    test_aw_before_w();
    test_rsp_backpressure();
    test_reset_mid();
    test_rresp_slverr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
